// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: op encoding,
// FSM state encoding, default widths and a counter-width helper.
package shift_sequencer_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_SHAMT_W = 5;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of the stage counter that walks shamt bits 0..shamt_w-1
    function automatic int cnt_width(input int shamt_w);
        return (shamt_w > 1) ? $clog2(shamt_w) : 1;
    endfunction

endpackage

// File: rtl/shift_stage_mux.sv
// One step of the sequential shifter: optionally shifts the accumulator by
// 2^cnt, left with zero fill or arithmetic right with sign fill.
module shift_stage_mux
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = DEFAULT_SHAMT_W,
    parameter int CNT_W   = cnt_width(DEFAULT_SHAMT_W)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [CNT_W-1:0] cnt,
    input  logic             op,
    input  logic             enable,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] sll_stage [SHAMT_W];
    logic [WIDTH-1:0] sra_stage [SHAMT_W];

    // Fixed-distance shifters, one pair per stage; pure wiring per stage
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        assign sll_stage[i] = acc << (2 ** i);
        assign sra_stage[i] = $signed(acc) >>> (2 ** i);
    end

    // Pick the stage selected by cnt, or pass acc through when disabled
    always_comb begin
        y = acc;
        if (enable) begin
            for (int i = 0; i < SHAMT_W; i++) begin
                if (cnt == CNT_W'(i)) begin
                    y = (op == OP_SRA) ? sra_stage[i] : sll_stage[i];
                end
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable shifter: walks shamt one bit per cycle, applying a
// 2^i stage to an accumulator, then presents the result with a done pulse.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int SHAMT_W    = DEFAULT_SHAMT_W,
    parameter int EARLY_EXIT = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int               CNT_W    = cnt_width(SHAMT_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHAMT_W - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   stage_out;
    logic [SHAMT_W-1:0] shamt_q;
    logic               op_q;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               stage_en;
    logic               upper_clear;
    logic               last_stage;

    // A start is only honoured outside SHIFT; requests during SHIFT are dropped
    assign accept      = start && (state != ST_SHIFT);
    assign stage_en    = shamt_q[cnt];
    assign upper_clear = ((shamt_q >> (32'(cnt) + 32'd1)) == '0);
    assign last_stage  = (cnt == LAST_CNT) || ((EARLY_EXIT != 0) && upper_clear);

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    shift_stage_mux #(
        .WIDTH  (WIDTH),
        .SHAMT_W(SHAMT_W),
        .CNT_W  (CNT_W)
    ) u_stage (
        .acc   (acc),
        .cnt   (cnt),
        .op    (op_q),
        .enable(stage_en),
        .y     (stage_out)
    );

    // Next-state logic: DONE always lasts one cycle, optionally chaining into SHIFT
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_SHIFT;
            ST_SHIFT: if (last_stage) state_next = ST_DONE;
            ST_DONE:  state_next = accept ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latches, stage counter, accumulator and the held result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            shamt_q <= '0;
            op_q    <= OP_SLL;
            cnt     <= '0;
            result  <= '0;
        end else if (accept) begin
            acc     <= data_in;
            shamt_q <= shamt;
            op_q    <= op;
            cnt     <= '0;
        end else if (state == ST_SHIFT) begin
            acc <= stage_out;
            cnt <= cnt + CNT_W'(1);
            if (last_stage) begin
                result <= stage_out;
            end
        end
    end

endmodule
